// File: rtl/tdmi_sched_pkg.sv
// Shared definitions for the TDMI scheduler: register offsets, TDMI_ALL field
// layout and FSM state encodings.
package tdmi_sched_pkg;

    localparam logic [15:0] TDMI_DATA    = 16'h0000;
    localparam logic [15:0] TDMI_CHANNEL = 16'h0004;
    localparam logic [15:0] TDMI_START   = 16'h0008;
    localparam logic [15:0] TDMI_ALL     = 16'h000C;

    localparam int CHAN_LSB = 8;
    localparam int DATA_LSB = 0;
    localparam int CHAN_W   = 5;
    localparam int DATA_W   = 8;
    localparam int SMP_W    = CHAN_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_READ = 2'd3
    } state_e;

    function automatic logic [CHAN_W-1:0] smp_chan(input logic [SMP_W-1:0] s);
        return s[CHAN_LSB +: CHAN_W];
    endfunction

    function automatic logic [DATA_W-1:0] smp_data(input logic [SMP_W-1:0] s);
        return s[DATA_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/tdmi_sched_fifo.sv
// Synchronous show-ahead sample FIFO; a pop on a full FIFO frees the slot for a
// same-cycle push.
module tdmi_sched_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/tdmi_sched.sv
// Wishbone master that arms the TDMI block and drains its samples into a FIFO.
// Optional TDMI_SCHED_SEQCHK_EN adds a channel-sequence checker and o_seq_err.
//
//   state | meaning
//   IDLE  | disabled, pending event discarded
//   ARM   | write 1 to TDMI_START
//   WAIT  | armed, waiting for a pending sample event
//   READ  | read TDMI_ALL and queue the sample
module tdmi_sched
    import tdmi_sched_pkg::*;
#(
    parameter logic [15:0] SLAVE_BASE  = 16'h0000,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_clr,
    input  logic        new_data_int,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_smp_valid,
    output logic [4:0]  o_smp_chan,
    output logic [7:0]  o_smp_data,
    input  logic        i_smp_ready,
    output logic        o_busy,
    output logic        o_err,
`ifdef TDMI_SCHED_SEQCHK_EN
    output logic        o_seq_err,
`endif
    output logic        o_overrun
);
    localparam int TW = $clog2(ACK_TIMEOUT);

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q, sync3_q, evt;
    logic              pend_q, pend_d;
    logic              cyc_q, we_q, cyc_d, we_d;
    logic [31:0]       adr_q, dat_q, adr_d, dat_d;
    logic [TW-1:0]     cnt_q;
    logic              timeout, ack_ok, bus_fail, consume;
    logic              push_req, pop, drop, fifo_full, fifo_empty;
    logic [SMP_W-1:0]  head;
    logic              err_q, ovr_q;
    logic              unused_dat;

    assign evt      = sync2_q & ~sync3_q;
    assign timeout  = cyc_q & (cnt_q == '0);
    assign ack_ok   = cyc_q & i_wb_ack & ~i_wb_err;
    assign bus_fail = cyc_q & (i_wb_err | (timeout & ~i_wb_ack));
    assign consume  = (state_q == ST_WAIT) & i_enable & pend_q;
    assign push_req = (state_q == ST_READ) & ack_ok;
    assign pop      = o_smp_valid & i_smp_ready;
    assign drop     = push_req & fifo_full & ~pop;
    assign unused_dat = ^i_wb_dat[31:SMP_W];

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_enable) state_d = ST_ARM;
            ST_ARM: begin
                if (ack_ok)        state_d = ST_WAIT;
                else if (bus_fail) state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (!i_enable)   state_d = ST_IDLE;
                else if (pend_q) state_d = ST_READ;
            end
            ST_READ: if (ack_ok || bus_fail) state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they land in flops
    always_comb begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = '0;
        dat_d = '0;
        case (state_d)
            ST_ARM: begin
                cyc_d = 1'b1;
                we_d  = 1'b1;
                adr_d = {SLAVE_BASE, TDMI_START};
                dat_d = 32'h1;
            end
            ST_READ: begin
                cyc_d = 1'b1;
                adr_d = {SLAVE_BASE, TDMI_ALL};
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_IDLE) pend_d = 1'b0;
        else if (evt)           pend_d = 1'b1;
        else if (consume)       pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= TW'(ACK_TIMEOUT - 1);
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cnt_q   <= cyc_q ? cnt_q - TW'(1) : TW'(ACK_TIMEOUT - 1);
            sync1_q <= new_data_int;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pend_q  <= pend_d;
            if (bus_fail)   err_q <= 1'b1;
            else if (i_clr) err_q <= 1'b0;
            // An event coinciding with pend being consumed is not lost
            if ((evt & pend_q & ~consume & (state_q != ST_IDLE)) | drop) ovr_q <= 1'b1;
            else if (i_clr) ovr_q <= 1'b0;
        end
    end

    tdmi_sched_fifo #(
        .WIDTH (SMP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .wdata_i (i_wb_dat[SMP_W-1:0]),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef TDMI_SCHED_SEQCHK_EN
    logic              seq_vld_q, seq_err_q;
    logic [CHAN_W-1:0] seq_exp_q, rx_chan;

    assign rx_chan   = i_wb_dat[CHAN_LSB +: CHAN_W];
    assign o_seq_err = seq_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_vld_q <= 1'b0;
            seq_exp_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            if (state_q == ST_ARM) begin
                seq_vld_q <= 1'b0;
            end else if (push_req && (!fifo_full || pop)) begin
                seq_vld_q <= 1'b1;
                seq_exp_q <= rx_chan + CHAN_W'(1);
                seq_err_q <= seq_vld_q & (rx_chan != seq_exp_q);
            end
        end
    end
`endif

    assign o_wb_adr    = adr_q;
    assign o_wb_sel    = 4'hF;
    assign o_wb_we     = we_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_smp_valid = ~fifo_empty;
    assign o_smp_chan  = smp_chan(head);
    assign o_smp_data  = smp_data(head);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_err       = err_q;
    assign o_overrun   = ovr_q;

endmodule
